// File: rtl/serial_feeder_pkg.sv
// Shared types and sizing helpers for the serial feeder that drives machine_d.x.
`timescale 1ns/1ps
package serial_feeder_pkg;

  localparam int   WIDTH_DEF    = 22;
  localparam logic IDLE_BIT_DEF = 1'b0;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int len_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_feeder_if.sv
// Valid/ready load channel carrying a word and its bit count into the feeder.
`timescale 1ns/1ps
interface serial_feeder_if
  import serial_feeder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LEN_W = len_w(WIDTH)
) ();

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [LEN_W-1:0] load_len;

  modport master (output load_valid, load_data, load_len, input load_ready);
  modport slave  (input load_valid, load_data, load_len, output load_ready);

endinterface

// File: rtl/serial_feeder_buf.sv
// One-entry holding register; stores the word with its length already clamped.
`timescale 1ns/1ps
module serial_feeder_buf
  import serial_feeder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LEN_W = len_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic [LEN_W-1:0] load_len_i,
  input  logic             consume_i,
  output logic             load_ready_o,
  output logic             buf_full_o,
  output logic [WIDTH-1:0] buf_data_o,
  output logic [LEN_W-1:0] buf_len_o
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] len_clamped;
  logic             accept;

  // No bypass: readiness follows the registered flag only.
  assign load_ready_o = rst & ~full_q;
  assign accept       = load_valid_i & load_ready_o;

  always_comb begin
    len_clamped = load_len_i;
    if (load_len_i == '0 || load_len_i > LEN_MAX) len_clamped = LEN_MAX;
  end

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    len_d  = len_q;
    if (accept) begin
      full_d = 1'b1;
      data_d = load_data_i;
      len_d  = len_clamped;
    end else if (consume_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= 1'b0;
      data_q <= '0;
      len_q  <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      len_q  <= len_d;
    end
  end

  assign buf_full_o = full_q;
  assign buf_data_o = data_q;
  assign buf_len_o  = len_q;

endmodule

// File: rtl/serial_feeder.sv
// Serializes buffered words LSB first onto x, one bit per clock, gapless when chained.
// state | meaning:  IDLE | x at idle level, waiting for a buffered word;  SHIFT | x carries word bit count_q
`timescale 1ns/1ps
module serial_feeder
  import serial_feeder_pkg::*;
#(
  parameter int   WIDTH    = WIDTH_DEF,
  parameter logic IDLE_BIT = IDLE_BIT_DEF,
  parameter int   LEN_W    = len_w(WIDTH)
) (
  input  logic           clk,
  input  logic           rst,
  serial_feeder_if.slave load_if,
  input  logic           hold_i,
  output logic           x_o,
  output logic           x_valid_o,
  output logic           word_start_o,
  output logic           done_o
);

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  logic             buf_full;
  logic [WIDTH-1:0] buf_data;
  logic [LEN_W-1:0] buf_len;
  logic             last, consume;

  state_e           state_q;
  logic [WIDTH-2:0] shreg_q;
  logic [LEN_W-1:0] len_q, count_q;
  logic             x_q, x_valid_q, word_start_q, done_q;

  serial_feeder_buf #(.WIDTH(WIDTH), .LEN_W(LEN_W)) u_buf (
    .clk          (clk),
    .rst          (rst),
    .load_valid_i (load_if.load_valid),
    .load_data_i  (load_if.load_data),
    .load_len_i   (load_if.load_len),
    .consume_i    (consume),
    .load_ready_o (load_if.load_ready),
    .buf_full_o   (buf_full),
    .buf_data_o   (buf_data),
    .buf_len_o    (buf_len)
  );

  assign last    = (count_q == len_q - ONE);
  assign consume = ~hold_i & buf_full & ((state_q == IDLE) | last);

  // shreg_q holds only the bits not yet presented; bit 0 goes straight to x_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      len_q        <= '0;
      count_q      <= '0;
      x_q          <= IDLE_BIT;
      x_valid_q    <= 1'b0;
      word_start_q <= 1'b0;
      done_q       <= 1'b0;
    end else if (hold_i) begin
      done_q <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      word_start_q <= 1'b0;
      if (consume) begin
        shreg_q      <= buf_data[WIDTH-1:1];
        len_q        <= buf_len;
        count_q      <= '0;
        x_q          <= buf_data[0];
        x_valid_q    <= 1'b1;
        word_start_q <= 1'b1;
        done_q       <= (state_q == SHIFT);
        state_q      <= SHIFT;
      end else if (state_q == SHIFT) begin
        if (last) begin
          state_q   <= IDLE;
          count_q   <= '0;
          x_q       <= IDLE_BIT;
          x_valid_q <= 1'b0;
          done_q    <= 1'b1;
        end else begin
          shreg_q <= shreg_q >> 1;
          x_q     <= shreg_q[0];
          count_q <= count_q + ONE;
        end
      end
    end
  end

  assign x_o          = x_q;
  assign x_valid_o    = x_valid_q;
  assign word_start_o = word_start_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_serial_feeder.sv
// Directed bench for serial_feeder: reset, chaining, hold, len=1 gaps, async reset, length clamp.
`timescale 1ns/1ps
module tb_serial_feeder;

  localparam int W  = 22;
  localparam int LW = 5;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic hold = 1'b0;
  logic x, xv, ws, done;
  int   total  = 0;
  int   passed = 0;

  logic [W-1:0] w_t1 = 22'b0001111000000111000100;
  logic [W-1:0] w_a5 = 22'h0000A5;
  logic [W-1:0] w_3c = 22'h00003C;
  logic [W-1:0] w_0f = 22'h00000F;
  logic [W-1:0] w_r1 = 22'h3A5C7F;
  logic [W-1:0] w_r2 = 22'h155555;
  logic [W-1:0] w_cl = 22'h2F0E5A;

  serial_feeder_if #(.WIDTH(W), .LEN_W(LW)) lif ();

  serial_feeder #(.WIDTH(W), .IDLE_BIT(1'b0), .LEN_W(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_if      (lif.slave),
    .hold_i       (hold),
    .x_o          (x),
    .x_valid_o    (xv),
    .word_start_o (ws),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [3:0] outs();
    return {x, xv, ws, done};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to the next falling edge; drop load_valid if the rising edge accepted it.
  task automatic tick();
    automatic bit acc = lif.load_valid && lif.load_ready;
    @(negedge clk);
    if (acc) lif.load_valid = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d, input logic [LW-1:0] l);
    lif.load_data  = d;
    lif.load_len   = l;
    lif.load_valid = 1'b1;
    for (int i = 0; i < 50 && lif.load_valid; i++) tick();
    check("send_accepted", lif.load_valid, 1'b0);
    lif.load_valid = 1'b0;
  endtask

  task automatic check_word(input string tag, input logic [W-1:0] d, input int first,
                            input int n, input bit chained);
    for (int i = first; i < n; i++) begin
      check(tag, outs(), {d[i], 1'b1, (i == 0), (i == 0 && chained)});
      tick();
    end
  endtask

  task automatic check_done(input string tag);
    check(tag, outs(), 4'b0001);
    tick();
  endtask

  initial begin
    lif.load_valid = 1'b0;
    lif.load_data  = '0;
    lif.load_len   = '0;

    // reset
    #20;
    check("reset_outs", outs(), 4'b0000);
    check("reset_ready", lif.load_ready, 1'b0);
    #7 rst = 1'b1;
    @(negedge clk);
    check("ready_after_reset", lif.load_ready, 1'b1);

    // 1: single 22-bit word, len=0 means full width
    send(w_t1, 5'd0);
    check("t1_ready_full", lif.load_ready, 1'b0);
    check("t1_latency", outs(), 4'b0000);
    tick();
    check_word("t1_bit", w_t1, 0, 22, 1'b0);
    check_done("t1_done");
    check("t1_idle", outs(), 4'b0000);

    // 2: back-to-back bytes
    send(w_a5, 5'd8);
    lif.load_data  = w_3c;
    lif.load_len   = 5'd8;
    lif.load_valid = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      check("t2_a5_bit", outs(), {w_a5[i], 1'b1, (i == 0), 1'b0});
      check("t2_ready", lif.load_ready, (i == 0));
      tick();
    end
    check("t2_ready_bit9", lif.load_ready, 1'b1);
    check_word("t2_3c_bit", w_3c, 0, 8, 1'b1);
    check_done("t2_done");
    check("t2_idle", outs(), 4'b0000);

    // 3: hold for three cycles on the first bit of the second word
    send(w_0f, 5'd4);
    lif.load_data  = w_0f;
    lif.load_len   = 5'd4;
    lif.load_valid = 1'b1;
    tick();
    check_word("t3_w1_bit", w_0f, 0, 4, 1'b0);
    check("t3_w2_bit0", outs(), 4'b1111);
    hold = 1'b1;
    repeat (3) begin
      tick();
      check("t3_held", outs(), 4'b1110);
    end
    hold = 1'b0;
    tick();
    check_word("t3_w2_bit", w_0f, 1, 4, 1'b0);
    check_done("t3_done");
    check("t3_idle", outs(), 4'b0000);

    // 4: len=1 words 1,0,1 with load_valid held high
    lif.load_len   = 5'd1;
    lif.load_data  = 22'd1;
    lif.load_valid = 1'b1;
    @(negedge clk);
    lif.load_data = 22'd0;
    check("t4_c1", outs(), 4'b0000);
    check("t4_c1_ready", lif.load_ready, 1'b0);
    @(negedge clk);
    check("t4_c2", outs(), 4'b1110);
    @(negedge clk);
    lif.load_data = 22'd1;
    check("t4_c3", outs(), 4'b0001);
    @(negedge clk);
    check("t4_c4", outs(), 4'b0110);
    @(negedge clk);
    lif.load_valid = 1'b0;
    check("t4_c5", outs(), 4'b0001);
    @(negedge clk);
    check("t4_c6", outs(), 4'b1110);
    @(negedge clk);
    check("t4_c7", outs(), 4'b0001);
    @(negedge clk);
    check("t4_c8", outs(), 4'b0000);

    // 5: asynchronous reset during bit 10 with the buffer full
    send(w_r1, 5'd22);
    lif.load_data  = w_r2;
    lif.load_len   = 5'd0;
    lif.load_valid = 1'b1;
    tick();
    check_word("t5_bit", w_r1, 0, 10, 1'b0);
    check("t5_bit10", outs(), 4'b1100);
    check("t5_buf_full", lif.load_ready, 1'b0);
    #1 rst = 1'b0;
    #1;
    check("t5_async_outs", outs(), 4'b0000);
    check("t5_ready_in_reset", lif.load_ready, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("t5_ready_after", lif.load_ready, 1'b1);
    @(negedge clk);
    repeat (4) begin
      check("t5_stays_idle", outs(), 4'b0000);
      tick();
    end

    // 6: load_len above WIDTH clamps to 22 bits
    send(w_cl, 5'd30);
    tick();
    check_word("t6_bit", w_cl, 0, 22, 1'b0);
    check_done("t6_done");
    check("t6_idle", outs(), 4'b0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/serial_feeder.md
Name: serial_feeder

Overview:
- Upstream stage for the sequence-detector FSM `machine_d`. Converts parallel words into the serial bit stream `x` that `machine_d` samples, one bit per clock, LSB first.
- Holds one word in a holding buffer while the shift register drains, so consecutive words stream with no gap.
- Replaces ad-hoc bench shift logic and lets stimulus or upstream logic present words through a valid/ready handshake.

Parameters:
- WIDTH, 22: maximum word length in bits.
- IDLE_BIT, 1'b0: level driven on x when no word is being shifted.
- LEN_W, $clog2(WIDTH+1): width of the length field.

Ports:
- clk  in  1  rising-edge clock, shared with machine_d.
- rst  in  1  asynchronous, active-low reset.
- load_valid  in  1  load_data/load_len are presented.
- load_ready  out  1  holding buffer can accept a word.
- load_data  in  WIDTH  word to serialize; bit 0 is sent first.
- load_len  in  LEN_W  number of bits to send; 0 or >WIDTH means WIDTH.
- hold  in  1  freezes the serial output.
- x  out  1  serial bit to machine_d.x; registered.
- x_valid  out  1  x carries a word bit.
- word_start  out  1  high while x carries bit 0 of a word.
- done  out  1  one-cycle pulse after the last bit of a word has been presented.

Behaviour:
- Reset (rst=0, async):
  - x=IDLE_BIT, x_valid=0, word_start=0, done=0.
  - Buffer empty, state IDLE, count=0.
  - load_ready is forced to 0 while rst=0.
  - Reset mid-word discards both the shifter word and the buffered word.
- load_ready = rst & !buf_full. There is no bypass; a buffer emptying on an edge does not raise load_ready in that same cycle.
- Accept occurs on a posedge where load_valid & load_ready. Data and the clamped length are stored in the buffer; buf_full=1.
- States: IDLE, SHIFT.
- IDLE:
  - x=IDLE_BIT, x_valid=0.
  - On a posedge with buf_full & !hold: load the shifter from the buffer, clear buf_full, go to SHIFT.
  - After that edge: x=bit0, x_valid=1, word_start=1, count=0.
- Latency: a handshake at edge N gives the first bit on x after edge N+1 (if hold=0).
- SHIFT, each posedge with hold=0:
  - count<len-1: shift right, count++, word_start=0.
  - count==len-1 (last bit), buf_full: load the next word and pulse done=1. The first bit of the new word appears in the same cycle as done; word_start=1. No idle gap.
  - count==len-1, buffer empty: go to IDLE, x=IDLE_BIT, x_valid=0, done=1 for one cycle.
- hold=1:
  - x, x_valid, word_start, count and state are frozen; done=0.
  - Buffer loads are still accepted.
  - hold does not delay the reset response.
- Words with len=1 back-to-back:
  - The buffer refill can land on the same edge that consumes the last bit.
  - The shifter sees buf_full=0, so one IDLE cycle is inserted. This is required behaviour, not a bug.
- done is never asserted while x_valid=0 except on the cycle immediately following a final bit.
- Arithmetic:
  - count is LEN_W bits and never exceeds WIDTH-1.
  - Shift is a logical right shift with zero fill.
  - Length clamp: len = (load_len==0 || load_len>WIDTH) ? WIDTH : load_len.

Decomposition:
- Package serial_feeder_pkg:
  - state enum {IDLE, SHIFT}.
  - Default WIDTH, and the LEN_W calculation helper.
  - IDLE_BIT default.
- One natural sub-module: serial_feeder_buf, the one-entry holding register with full flag, valid/ready, and length clamp. The top keeps the FSM, shifter and counter.

Test Plan:
1. Reset and single word:
   - Stimulus: hold rst=0 for 27 ns, release. Load 22'b0001111000000111000100 with len=0.
   - Response: x (LSB first) = 0,0,1,0,0,0,1,1,1,0,0,0,0,0,0,1,1,1,1,0,0,0 over 22 cycles. x_valid=1 throughout; word_start only on the first cycle; done pulses once; then x=0, x_valid=0.
2. Back-to-back words:
   - Stimulus: load 8'hA5 (len 8), then while it shifts load 8'h3C (len 8).
   - Response: 16 consecutive valid bits 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0. done and word_start coincide at bit 9. load_ready=0 from the second accept until bit 9.
3. Hold:
   - Stimulus: assert hold for 3 cycles at bit 5 of word 0x0F (len 4, then 4'b1111 in a second word).
   - Response: x and count stay frozen for exactly 3 cycles; the sequence resumes unchanged; no extra done.
4. len=1 back-to-back:
   - Stimulus: words 1, 0, 1 with len=1 and load_valid held high.
   - Response: bits 1,0,1 each separated by exactly one x_valid=0 cycle; one done per word.
5. Reset mid-word:
   - Stimulus: drop rst for 2 ns during bit 10 of a 22-bit word, with the buffer full.
   - Response: x=0 and x_valid=0 immediately (asynchronous), load_ready=0 during reset and 1 after. The buffered word is lost; x stays idle until a new load.
6. Length clamp:
   - Stimulus: load_len=30 with WIDTH=22.
   - Response: exactly 22 bits are sent, then done.
